// File: rtl/plic_pkg.sv
// Shared definitions for the platform-level interrupt controller:
// register offsets, gateway state encoding and default sizing.
package plic_pkg;

    localparam int NSRC_DEFAULT   = 8;
    localparam int PRIO_W_DEFAULT = 3;

    // Byte offsets within the 4 KiB PLIC window
    localparam logic [11:0] ADDR_PRIO_BASE = 12'h000;
    localparam logic [11:0] ADDR_PENDING   = 12'h080;
    localparam logic [11:0] ADDR_ENABLE    = 12'h100;
    localparam logic [11:0] ADDR_THRESHOLD = 12'h200;
    localparam logic [11:0] ADDR_CLAIM     = 12'h204;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    // Word index of a byte offset (low two address bits are ignored)
    function automatic logic [9:0] word_of(input logic [11:0] addr);
        return addr[11:2];
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: latches a level request, holds it until
// claimed, then blocks the source until the handler writes completion.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_e state;

    // Gateway state machine; the source level is only sampled while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GW_IDLE;
        end else begin
            case (state)
                GW_IDLE:     if (src)      state <= GW_PENDING;
                GW_PENDING:  if (claim)    state <= GW_INFLIGHT;
                GW_INFLIGHT: if (complete) state <= GW_IDLE;
                default:                   state <= GW_IDLE;
            endcase
        end
    end

    assign pending = (state == GW_PENDING);

endmodule

// File: rtl/irq_plic.sv
// Platform-level interrupt controller: per-source priority, enable bitmap,
// threshold, claim/complete handshake and a registered core interrupt line.
module irq_plic
    import plic_pkg::*;
#(
    parameter int NSRC   = NSRC_DEFAULT,
    parameter int PRIO_W = PRIO_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [11:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic              irq_ext
);

    localparam int ID_W = $clog2(NSRC + 1);

    logic [PRIO_W-1:0] prio [1:NSRC];
    logic [NSRC:1]     enable;
    logic [PRIO_W-1:0] threshold;

    logic [NSRC:1]     pending;
    logic [NSRC:1]     eligible;
    logic [NSRC:1]     claim_vec;
    logic [NSRC:1]     complete_vec;
    logic [ID_W-1:0]   winner_id;
    logic [PRIO_W-1:0] best_prio;
    logic [31:0]       rdata_next;

    logic       rd_en;
    logic       wr_en;
    logic [9:0] word;
    logic       hit_claim;
    logic       unused_addr_lsb;

    assign rd_en           = bus_req & ~bus_we;
    assign wr_en           = bus_req & bus_we;
    assign word            = word_of(bus_addr);
    assign hit_claim       = (word == word_of(ADDR_CLAIM));
    assign unused_addr_lsb = ^bus_addr[1:0];

    // One gateway per source ID; IDs start at 1, ID 0 means "none"
    for (genvar g = 1; g <= NSRC; g++) begin : g_gw
        plic_gateway u_gw (
            .clk      (clk),
            .rst      (rst),
            .src      (irq_src[g-1]),
            .claim    (claim_vec[g]),
            .complete (complete_vec[g]),
            .pending  (pending[g])
        );
    end

    // Sources that could currently be delivered to the core
    always_comb begin
        eligible = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            eligible[i] = pending[i] && enable[i] && (prio[i] > threshold);
        end
    end

    // Winner: highest priority among eligible sources, lowest ID on ties
    always_comb begin
        winner_id = '0;
        best_prio = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (eligible[i] && ((winner_id == '0) || (prio[i] > best_prio))) begin
                winner_id = ID_W'(i);
                best_prio = prio[i];
            end
        end
    end

    // Claim and complete strobes decoded to one-hot per source
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            claim_vec[i]    = rd_en && hit_claim && (winner_id == ID_W'(i));
            complete_vec[i] = wr_en && hit_claim && (bus_wdata == 32'(i));
        end
    end

    // Configuration register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i <= NSRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 1; i <= NSRC; i++) begin
                if (word == 10'(i)) begin
                    prio[i] <= bus_wdata[PRIO_W-1:0];
                end
            end
            if (word == word_of(ADDR_ENABLE)) begin
                enable <= bus_wdata[NSRC:1];
            end
            if (word == word_of(ADDR_THRESHOLD)) begin
                threshold <= bus_wdata[PRIO_W-1:0];
            end
        end
    end

    // Read data multiplexer; unmapped offsets read as zero
    always_comb begin
        rdata_next = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (word == 10'(i)) begin
                rdata_next[PRIO_W-1:0] = prio[i];
            end
        end
        if (word == word_of(ADDR_PENDING)) begin
            rdata_next[NSRC:1] = pending;
        end
        if (word == word_of(ADDR_ENABLE)) begin
            rdata_next[NSRC:1] = enable;
        end
        if (word == word_of(ADDR_THRESHOLD)) begin
            rdata_next[PRIO_W-1:0] = threshold;
        end
        if (hit_claim) begin
            rdata_next[ID_W-1:0] = winner_id;
        end
    end

    // Registered bus response and core interrupt; the source being claimed
    // this cycle is excluded so irq_ext drops together with the claim
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
            irq_ext    <= 1'b0;
        end else begin
            bus_rvalid <= rd_en;
            if (rd_en) begin
                bus_rdata <= rdata_next;
            end
            irq_ext <= |(eligible & ~claim_vec);
        end
    end

endmodule

// File: tb/tb_irq_plic.sv
// Self-checking bench for irq_plic: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the controller.
module tb_irq_plic;

    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] irq_src = '0;
    logic            bus_req = 1'b0;
    logic            bus_we = 1'b0;
    logic [11:0]     bus_addr = '0;
    logic [31:0]     bus_wdata = '0;
    logic [31:0]     bus_rdata;
    logic            bus_rvalid;
    logic            irq_ext;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = pending, 2 = in service
    int      m_state [1:NSRC];
    int      m_prio  [1:NSRC];
    bit      m_en    [1:NSRC];
    int      m_thr;
    bit      m_rvalid;
    int      m_rdata;
    bit      m_irq;

    irq_plic #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq_ext    (irq_ext)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic bit m_can_win(int id);
        return m_state[id] == 1 && m_en[id] && m_prio[id] > m_thr;
    endfunction

    function automatic int m_winner();
        int best = 0;
        for (int id = 1; id <= NSRC; id++)
            if (m_can_win(id) && (best == 0 || m_prio[id] > m_prio[best])) best = id;
        return best;
    endfunction

    function automatic int m_read(logic [11:0] a, int w);
        int off = int'(a) & 'hFFC;
        int v = 0;
        if (off >= 4 && off <= 4 * NSRC) return m_prio[off / 4];
        if (off == 'h080) begin
            for (int id = 1; id <= NSRC; id++) if (m_state[id] == 1) v += (1 << id);
            return v;
        end
        if (off == 'h100) begin
            for (int id = 1; id <= NSRC; id++) if (m_en[id]) v += (1 << id);
            return v;
        end
        if (off == 'h200) return m_thr;
        if (off == 'h204) return w;
        return 0;
    endfunction

    // Advance one clock: evaluate the spec rules on the presented inputs,
    // then let the DUT take the same edge and sample 1 time unit later.
    task automatic tick();
        int w, claimed, off, wd;
        int nstate [1:NSRC];
        if (rst) begin
            for (int id = 1; id <= NSRC; id++) begin
                nstate[id] = 0; m_prio[id] = 0; m_en[id] = 0;
            end
            m_thr = 0; m_rvalid = 0; m_rdata = 0; m_irq = 0;
        end else begin
            w = m_winner();
            off = int'(bus_addr) & 'hFFC;
            wd = int'(bus_wdata);
            claimed = (bus_req && !bus_we && off == 'h204) ? w : 0;
            m_rvalid = bus_req && !bus_we;
            if (m_rvalid) m_rdata = m_read(bus_addr, w);
            m_irq = 0;
            for (int id = 1; id <= NSRC; id++)
                if (id != claimed && m_can_win(id)) m_irq = 1;
            for (int id = 1; id <= NSRC; id++) begin
                nstate[id] = m_state[id];
                if (m_state[id] == 0 && irq_src[id-1]) nstate[id] = 1;
                if (m_state[id] == 1 && claimed == id) nstate[id] = 2;
                if (m_state[id] == 2 && bus_req && bus_we && off == 'h204 &&
                    bus_wdata == 32'(id)) nstate[id] = 0;
            end
            if (bus_req && bus_we) begin
                if (off >= 4 && off <= 4 * NSRC) m_prio[off / 4] = wd & 7;
                if (off == 'h100) for (int id = 1; id <= NSRC; id++) m_en[id] = bus_wdata[id];
                if (off == 'h200) m_thr = wd & 7;
            end
        end
        for (int id = 1; id <= NSRC; id++) m_state[id] = nstate[id];
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic v);
        bus_req = 1; bus_we = 0; bus_addr = a;
        tick();
        bus_req = 0;
        d = bus_rdata; v = bus_rvalid;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] wd);
        bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = wd;
        tick();
        bus_req = 0; bus_we = 0;
    endtask

    task automatic reset_dut();
        irq_src = '0; bus_req = 0; bus_we = 0; rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        logic [11:0] regs [5] = '{12'h004, 12'h080, 12'h100, 12'h200, 12'h204};
        reset_dut();
        checks++;
        if (irq_ext !== 1'b0 || bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs irq=%b rvalid=%b rdata=%h exp 0/0/0", irq_ext, bus_rvalid, bus_rdata);
        end
        foreach (regs[k]) begin
            bus_read(regs[k], d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg_%h got v=%b d=%h exp v=1 d=0", regs[k], v, d);
            end
        end
    endtask

    task automatic test_basic_latency();
        logic [31:0] d; logic v;
        reset_dut();
        bus_write(12'h00C, 5);
        bus_write(12'h100, 32'h8);
        bus_write(12'h200, 0);
        irq_src[2] = 1;
        tick();
        checks++;
        if (irq_ext !== 1'b0) begin errors++; $display("FAIL lat_n1 irq=%b exp 0", irq_ext); end
        tick();
        checks++;
        if (irq_ext !== 1'b1) begin errors++; $display("FAIL lat_n2 irq=%b exp 1", irq_ext); end
        bus_read(12'h204, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd3) begin errors++; $display("FAIL claim3 v=%b d=%0d exp v=1 d=3", v, d); end
        checks++;
        if (irq_ext !== 1'b0) begin errors++; $display("FAIL irq_after_claim irq=%b exp 0", irq_ext); end
        irq_src = '0;
        bus_write(12'h204, 3);
        tick(); tick();
        checks++;
        if (irq_ext !== 1'b0) begin errors++; $display("FAIL irq_after_complete irq=%b exp 0", irq_ext); end
    endtask

    task automatic test_back_to_back();
        int exp_ids [3] = '{2, 5, 0};
        reset_dut();
        bus_write(12'h008, 4);
        bus_write(12'h014, 4);
        bus_write(12'h100, 32'h24);
        irq_src = 8'b0001_0010;
        tick();
        irq_src = '0;
        tick(); tick();
        checks++;
        if (irq_ext !== 1'b1) begin errors++; $display("FAIL tie_irq irq=%b exp 1", irq_ext); end
        bus_req = 1; bus_we = 0; bus_addr = 12'h204;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_rvalid !== 1'b1 || bus_rdata !== 32'(exp_ids[k])) begin
                errors++;
                $display("FAIL tie_claim%0d v=%b d=%0d exp v=1 d=%0d", k, bus_rvalid, bus_rdata, exp_ids[k]);
            end
        end
        bus_req = 0;
    endtask

    task automatic test_threshold();
        logic [31:0] d; logic v;
        reset_dut();
        bus_write(12'h004, 2);
        bus_write(12'h200, 2);
        bus_write(12'h100, 32'h2);
        irq_src[0] = 1;
        tick(); tick(); tick();
        checks++;
        if (irq_ext !== 1'b0) begin errors++; $display("FAIL thr_block irq=%b exp 0", irq_ext); end
        bus_read(12'h204, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL thr_claim v=%b d=%0d exp v=1 d=0", v, d); end
        bus_write(12'h200, 1);
        tick();
        checks++;
        if (irq_ext !== 1'b1) begin errors++; $display("FAIL thr_lower irq=%b exp 1", irq_ext); end
        irq_src = '0;
        bus_write(12'h004, 32'hFFFF_FFFA);
        bus_read(12'h004, d, v);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL prio_trunc d=%h exp 2", d); end
    endtask

    task automatic test_repend();
        logic [31:0] d; logic v;
        reset_dut();
        bus_write(12'h010, 1);
        bus_write(12'h100, 32'h10);
        irq_src[3] = 1;
        tick(); tick();
        bus_read(12'h204, d, v);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL repend_claim d=%0d exp 4", d); end
        bus_write(12'h204, 4);
        bus_read(12'h080, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL repend_idle d=%h exp 0", d); end
        bus_read(12'h080, d, v);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL repend_set d=%h exp 10", d); end
        bus_read(12'h204, d, v);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL repend_claim2 d=%0d exp 4", d); end
        bus_write(12'h204, 6);
        bus_read(12'h080, d, v);
        checks++;
        if (d !== 32'h0 || irq_ext !== 1'b0) begin
            errors++; $display("FAIL bad_complete pend=%h irq=%b exp 0/0", d, irq_ext);
        end
        irq_src = '0;
        bus_write(12'h204, 4);
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; logic v;
        logic [11:0] regs [5] = '{12'h004, 12'h080, 12'h100, 12'h200, 12'h204};
        reset_dut();
        bus_write(12'h004, 3);
        bus_write(12'h100, 32'h2);
        irq_src[0] = 1;
        tick();
        irq_src = '0;
        tick();
        bus_req = 1; bus_we = 0; bus_addr = 12'h080; rst = 1;
        tick();
        checks++;
        if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0 || irq_ext !== 1'b0) begin
            errors++; $display("FAIL rst_mid_read v=%b d=%h irq=%b exp 0", bus_rvalid, bus_rdata, irq_ext);
        end
        rst = 0; bus_req = 0;
        tick();
        checks++;
        if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid v=%b exp 0", bus_rvalid); end
        foreach (regs[k]) begin
            bus_read(regs[k], d, v);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL post_rst_%h d=%h exp 0", regs[k], d); end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic v;
        reset_dut();
        irq_src[1] = 1;
        tick();
        irq_src = '0;
        tick();
        bus_read(12'h3F0, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_read v=%b d=%h exp 1/0", v, d); end
        bus_write(12'h080, 32'hFFFF_FFFF);
        bus_write(12'h3F0, 32'hFFFF_FFFF);
        bus_write(12'h000, 32'h7);
        bus_read(12'h081, d, v);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL pending_ro d=%h exp 4", d); end
        bus_read(12'h000, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL prio0_raz d=%h exp 0", d); end
        bus_write(12'h100, 32'hFFFF_FFFF);
        bus_read(12'h100, d, v);
        checks++;
        if (d !== 32'h1FE) begin errors++; $display("FAIL enable_mask d=%h exp 1fe", d); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [14] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                                   12'h018, 12'h01C, 12'h020, 12'h080, 12'h100,
                                   12'h200, 12'h204, 12'h3F0};
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < NSRC; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            bus_req = $urandom_range(0, 1);
            bus_we = $urandom_range(0, 2) == 0;
            bus_addr = addrs[$urandom_range(0, 13)] | 12'($urandom_range(0, 3));
            if (bus_addr[11:2] == 10'h081) bus_wdata = $urandom_range(0, 10);
            else if (bus_addr[11:2] == 10'h080) bus_wdata = $urandom_range(0, 3);
            else if (bus_addr[11:2] == 10'h040) bus_wdata = $urandom;
            else bus_wdata = $urandom_range(0, 15);
            tick();
            checks++;
            if (irq_ext !== m_irq || bus_rvalid !== m_rvalid) begin
                errors++;
                $display("FAIL rand_c%0d irq=%b rvalid=%b exp %b/%b", c, irq_ext, bus_rvalid, m_irq, m_rvalid);
            end
            if (m_rvalid) begin
                checks++;
                if (bus_rdata !== 32'(m_rdata)) begin
                    errors++;
                    $display("FAIL rand_rdata_c%0d d=%h exp %h", c, bus_rdata, m_rdata);
                end
            end
        end
        rst = 0; bus_req = 0; bus_we = 0;
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_threshold();
        test_repend();
        test_reset_mid_read();
        test_unmapped();
        reset_dut();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_plic.md
IRQ_PLIC -- requirements
Module: irq_plic

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources (IDs 1..NSRC; ID 0 = "none").
REQ-002 SHALL have parameter PRIO_W, default 3, meaning priority/threshold width in bits.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port irq_src  input  NSRC  level-sensitive sources; bit i-1 = source ID i.
REQ-006 SHALL have port bus_req  input  1  D-bus access strobe, one cycle per access.
REQ-007 SHALL have port bus_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port bus_addr  input  12  byte offset within the PLIC window; bits [1:0] ignored.
REQ-009 SHALL have port bus_wdata  input  32  write data.
REQ-010 SHALL have port bus_rdata  output  32  read data, valid while bus_rvalid=1.
REQ-011 SHALL have port bus_rvalid  output  1  read-data strobe.
REQ-012 SHALL have port irq_ext  output  1  registered external-interrupt request to the core.

Function
REQ-013 SHALL map registers: 0x000+4*i priority[i] (RW, i=1..NSRC; i=0 reads 0); 0x080 pending bitmap (RO, bit i = ID i); 0x100 enable bitmap (RW, bit 0 RAZ/WI); 0x200 threshold (RW); 0x204 claim/complete.
REQ-014 SHALL return 0 for reads of unmapped offsets and ignore writes to them or to RO registers.
REQ-015 SHALL truncate priority/threshold writes to PRIO_W bits and zero-extend on read.
REQ-016 SHALL assert bus_rvalid exactly one cycle after a read bus_req, with bus_rdata from that cycle; writes take effect on the edge ending the bus_req cycle and produce no bus_rvalid.
REQ-017 SHALL implement per-source gateway states IDLE, PENDING and INFLIGHT: IDLE -> PENDING when irq_src high; PENDING -> INFLIGHT on claim of that ID; INFLIGHT -> IDLE on complete write with that ID.
REQ-018 SHALL ignore irq_src while a source is PENDING or INFLIGHT; a source still high after completion re-pends on the following edge.
REQ-019 SHALL define the winner as the highest-priority ID that is pending, enabled and has priority > threshold, with ties going to the lowest ID; priority 0 never wins.
REQ-020 SHALL return the winner ID on a claim read (0 if none), and move that ID to INFLIGHT on the same edge the read is accepted.
REQ-021 SHALL ignore a complete write whose ID is 0, > NSRC, or not INFLIGHT.
REQ-022 SHALL register irq_ext = (winner exists). Latency: irq_src rises in cycle N, pending in N+1, irq_ext in N+2.
REQ-023 SHALL give a claim priority over a same-cycle rising irq_src of the same ID (result: INFLIGHT, no extra pending).
REQ-024 SHALL make enable, priority and threshold changes affect irq_ext one cycle after the write edge; disabling a source SHALL NOT clear its pending bit.

Reset
REQ-025 SHALL, while rst=1, clear all priorities, enables, threshold, pending and INFLIGHT state, and drive bus_rvalid=0, bus_rdata=0 and irq_ext=0.
REQ-026 SHALL discard any access presented during reset, including a read whose bus_rvalid would fall in the cycle after reset deasserts.

Structure
REQ-027 SHALL place address offsets, the gateway state enum and NSRC/PRIO_W defaults in package plic_pkg.
REQ-028 SHALL implement each gateway as sub-module plic_gateway, instantiated NSRC times.
REQ-029 SHALL implement winner selection as combinational logic inside irq_plic.
REQ-030 SHALL be wrapped by a separate slave_bus_if adapter, which is not part of this block.

Verification
REQ-031 SHALL cover: prio[3]=5, en bit3, thr=0, irq_src[2] high at cycle N -> irq_ext=1 at N+2; claim read returns 3 and irq_ext=0 in the cycle after the claim.
REQ-032 SHALL cover: IDs 2 and 5 both at prio 4, both pending and enabled -> claims return 2, then 5, then 0.
REQ-033 SHALL cover: prio[1]=2, thr=2 -> irq_ext stays 0 and claim returns 0; write thr=1 -> irq_ext=1 one cycle after the write.
REQ-034 SHALL cover: source 4 held high, claimed, then completed with ID 4 -> pending re-sets next edge; complete with ID 6 while not INFLIGHT -> no state change.
REQ-035 SHALL cover: reset asserted mid-read with source pending -> next-cycle bus_rvalid=0; all registers read 0 after release.
REQ-036 SHALL cover: read 0x3F0 -> rdata 0; write 0x080 -> pending unchanged.
